// File: rtl/alu_md_ctl_if.sv
// EX-stage decode and mul/div bundle between the pipeline and alu_md_ctl.
// The master drives the EX instruction fields; the slave returns decode and stall results.
interface alu_md_ctl_if #(
    parameter int unsigned DW = 32
);
    logic [5:0]    func;
    logic          r_type;
    logic          ex_valid;
    logic          flush;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic [4:0]    aluc;
    logic          sftmd;
    logic          jr_out;
    logic          jalr_out;
    logic          illegal;
    logic          stall;
    logic          md_busy;
    logic          hilo_rd;
    logic [DW-1:0] hilo_rdata;

    modport master (
        output func, r_type, ex_valid, flush, rs_val, rt_val,
        input  aluc, sftmd, jr_out, jalr_out, illegal, stall, md_busy, hilo_rd, hilo_rdata
    );

    modport slave (
        input  func, r_type, ex_valid, flush, rs_val, rt_val,
        output aluc, sftmd, jr_out, jalr_out, illegal, stall, md_busy, hilo_rd, hilo_rdata
    );
endinterface

// File: rtl/alu_md_ctl.sv
// EX-stage ALU control: R-type funct decode, HI/LO registers and radix-2 mul/div sequencer.
// Optional MD_EARLY_OUT_EN: multiplies finish early once the remaining multiplier bits are zero.
module alu_md_ctl #(
    parameter int unsigned DW = 32,
    parameter int unsigned CW = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_md_ctl_if.slave md
);
    localparam logic [5:0] FnMfhi = 6'b010000;
    localparam logic [5:0] FnMthi = 6'b010001;
    localparam logic [5:0] FnMflo = 6'b010010;
    localparam logic [5:0] FnMtlo = 6'b010011;
    localparam logic [5:0] FnJr   = 6'b001000;
    localparam logic [5:0] FnJalr = 6'b001001;
    localparam logic [CW-1:0] LastStep = CW'(DW - 1);

`ifdef MD_EARLY_OUT_EN
    localparam bit EarlyOut = 1'b1;
`else
    localparam bit EarlyOut = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_hi, r_lo;
    logic [DW-1:0] r_acc, r_mq, r_mcand;
    logic          r_is_div, r_neg, r_rneg, r_dz;

    logic [4:0]      w_aluc;
    logic            w_legal;
    logic            w_is_md, w_start, w_signed, w_div, w_rt_zero, w_stall, w_mt_wr;
    logic [DW-1:0]   w_rs_abs, w_rt_abs;
    logic [DW:0]     w_sum, w_shift, w_diff;
    logic [DW-1:0]   w_acc_n, w_mq_n;
    logic [2*DW-1:0] w_prod, w_early;
    logic [DW-1:0]   w_hi_fin, w_lo_fin, w_rest_mask;
    logic            w_rest_zero;

    always_comb begin
        w_aluc  = 5'b11111;
        w_legal = 1'b1;
        case (md.func)
            6'b100001: w_aluc = 5'b00000;
            6'b100011: w_aluc = 5'b00001;
            6'b101010: w_aluc = 5'b00010;
            6'b100100: w_aluc = 5'b00011;
            6'b100111: w_aluc = 5'b00100;
            6'b100101: w_aluc = 5'b00101;
            6'b100110: w_aluc = 5'b00110;
            6'b000000: w_aluc = 5'b00111;
            6'b000010: w_aluc = 5'b01000;
            6'b101011: w_aluc = 5'b01001;
            6'b001001: w_aluc = 5'b01010;
            6'b001000: w_aluc = 5'b01011;
            6'b000100: w_aluc = 5'b01100;
            6'b000011: w_aluc = 5'b01101;
            6'b000111: w_aluc = 5'b01110;
            6'b000110: w_aluc = 5'b01111;
            6'b010000: w_aluc = 5'b10000;
            6'b010001: w_aluc = 5'b10001;
            6'b010010: w_aluc = 5'b10010;
            6'b010011: w_aluc = 5'b10011;
            6'b011000: w_aluc = 5'b10100;
            6'b011001: w_aluc = 5'b10101;
            6'b011010: w_aluc = 5'b10110;
            6'b011011: w_aluc = 5'b10111;
            default:   w_legal = 1'b0;
        endcase
    end

    assign md.aluc       = w_aluc;
    assign md.illegal    = md.r_type & ~w_legal;
    assign md.sftmd      = (md.func == 6'b000000) | (md.func == 6'b000010) |
                           (md.func == 6'b000011);
    assign md.jr_out     = md.r_type & (md.func == FnJr);
    assign md.jalr_out   = md.r_type & (md.func == FnJalr);
    assign md.hilo_rd    = md.r_type & ((md.func == FnMfhi) | (md.func == FnMflo));
    assign md.hilo_rdata = (md.func == FnMfhi) ? r_hi : r_lo;

    // funct 0110xx: bit 0 selects unsigned, bit 1 selects divide
    assign w_is_md   = (md.func[5:2] == 4'b0110);
    assign w_signed  = ~md.func[0];
    assign w_div     = md.func[1];
    assign w_rt_zero = (md.rt_val == '0);
    assign w_start   = (r_state == StIdle) & md.ex_valid & md.r_type & ~md.flush & w_is_md;
    assign w_stall   = w_start | (r_state == StRun);
    assign w_mt_wr   = md.ex_valid & md.r_type & ~w_stall & ~md.flush;
    assign md.stall   = w_stall;
    assign md.md_busy = (r_state != StIdle);

    assign w_rs_abs = (w_signed & md.rs_val[DW-1]) ? -md.rs_val : md.rs_val;
    assign w_rt_abs = (w_signed & md.rt_val[DW-1]) ? -md.rt_val : md.rt_val;

    // One radix-2 step: r_acc holds product-high / partial remainder, r_mq multiplier / quotient
    always_comb begin
        w_sum   = {1'b0, r_acc} + {1'b0, r_mcand};
        w_shift = {r_acc, r_mq[DW-1]};
        w_diff  = w_shift - {1'b0, r_mcand};
        if (r_is_div) begin
            w_acc_n = w_diff[DW] ? w_shift[DW-1:0] : w_diff[DW-1:0];
            w_mq_n  = {r_mq[DW-2:0], ~w_diff[DW]};
        end else if (r_mq[0]) begin
            w_acc_n = w_sum[DW:1];
            w_mq_n  = {w_sum[0], r_mq[DW-1:1]};
        end else begin
            w_acc_n = {1'b0, r_acc[DW-1:1]};
            w_mq_n  = {r_acc[0], r_mq[DW-1:1]};
        end
    end

    always_comb begin
        w_prod = {w_acc_n, w_mq_n};
        if (r_neg) begin
            w_prod = -w_prod;
        end
        if (r_is_div) begin
            w_lo_fin = r_dz ? '1 : (r_neg ? -w_mq_n : w_mq_n);
            w_hi_fin = r_rneg ? -w_acc_n : w_acc_n;
        end else begin
            w_lo_fin = w_prod[DW-1:0];
            w_hi_fin = w_prod[2*DW-1:DW];
        end
        // Low DW-r_cnt bits of r_mq are the multiplier bits not yet consumed
        w_rest_mask = {DW{1'b1}} >> r_cnt;
        w_rest_zero = ((r_mq & w_rest_mask) == '0);
        w_early     = {r_acc, r_mq} >> (DW - 32'(r_cnt));
        if (r_neg) begin
            w_early = -w_early;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
            r_mq     <= '0;
            r_mcand  <= '0;
            r_is_div <= 1'b0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_state  <= StRun;
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_mq     <= w_rs_abs;
                        r_mcand  <= w_rt_abs;
                        r_is_div <= w_div;
                        r_dz     <= w_div & w_rt_zero;
                        r_neg    <= w_signed & (md.rs_val[DW-1] ^ md.rt_val[DW-1]) &
                                    ~(w_div & w_rt_zero);
                        r_rneg   <= w_signed & md.rs_val[DW-1];
                    end else if (w_mt_wr && md.func == FnMthi) begin
                        r_hi <= md.rs_val;
                    end else if (w_mt_wr && md.func == FnMtlo) begin
                        r_lo <= md.rs_val;
                    end
                end
                StRun: begin
                    if (md.flush) begin
                        r_state <= StIdle;
                    end else if (EarlyOut && !r_is_div && w_rest_zero) begin
                        r_hi    <= w_early[2*DW-1:DW];
                        r_lo    <= w_early[DW-1:0];
                        r_state <= StDone;
                    end else if (r_cnt == LastStep) begin
                        r_hi    <= w_hi_fin;
                        r_lo    <= w_lo_fin;
                        r_state <= StDone;
                    end else begin
                        r_acc <= w_acc_n;
                        r_mq  <= w_mq_n;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_md_ctl.sv
// Directed self-checking bench for alu_md_ctl: decode, mul/div results, stall timing, flush, moves.
module tb_alu_md_ctl;
    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;

    alu_md_ctl_if #(.DW(32)) md_if ();

    alu_md_ctl #(.DW(32), .CW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_idle();
        md_if.ex_valid = 1'b0;
        md_if.r_type   = 1'b0;
        md_if.func     = 6'b000000;
        md_if.flush    = 1'b0;
        md_if.rs_val   = '0;
        md_if.rt_val   = '0;
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        md_if.r_type   = 1'b1;
        md_if.ex_valid = 1'b1;
        md_if.func     = MFHI;
        #1 hi = md_if.hilo_rdata;
        md_if.func = MFLO;
        #1 lo = md_if.hilo_rdata;
        set_idle();
    endtask

    // Issues one mul/div, counts stall cycles, and reads HI/LO during the DONE cycle
    task automatic run_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        md_if.ex_valid = 1'b1;
        md_if.r_type   = 1'b1;
        md_if.flush    = 1'b0;
        md_if.func     = fn;
        md_if.rs_val   = a;
        md_if.rt_val   = b;
        cycles = 0;
        #1;
        while (md_if.stall === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        if (md_if.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL md_timeout: stall=%b after %0d cycles, want 0", md_if.stall, cycles);
        end
        md_if.func = MFHI;
        #1 hi = md_if.hilo_rdata;
        md_if.func = MFLO;
        #1 lo = md_if.hilo_rdata;
        set_idle();
    endtask

    task automatic test_reset();
        logic [31:0] hi, lo;
        set_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (md_if.stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %b want 0", md_if.stall);
        end
        n_cmp++;
        if (md_if.md_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", md_if.md_busy);
        end
        read_hilo(hi, lo);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo);
        end
    endtask

    task automatic test_decode();
        @(negedge clk);
        md_if.r_type = 1'b1;
        md_if.func   = 6'b101010;
        #1 n_cmp++;
        if (md_if.aluc !== 5'b00010) begin
            n_fail++; $display("FAIL dec_slt: got %b want 00010", md_if.aluc);
        end
        md_if.func = MULT;
        #1 n_cmp++;
        if (md_if.aluc !== 5'b10100) begin
            n_fail++; $display("FAIL dec_mult: got %b want 10100", md_if.aluc);
        end
        md_if.func = 6'b001000;
        #1 n_cmp++;
        if (md_if.jr_out !== 1'b1) begin
            n_fail++; $display("FAIL dec_jr: got %b want 1", md_if.jr_out);
        end
        md_if.r_type = 1'b0;
        #1 n_cmp++;
        if (md_if.jr_out !== 1'b0) begin
            n_fail++; $display("FAIL dec_jr_gated: got %b want 0", md_if.jr_out);
        end
        md_if.r_type = 1'b1;
        md_if.func   = 6'b111111;
        #1 n_cmp++;
        if (md_if.illegal !== 1'b1 || md_if.aluc !== 5'b11111) begin
            n_fail++;
            $display("FAIL dec_illegal: got %b/%b want 1/11111", md_if.illegal, md_if.aluc);
        end
        md_if.func = 6'b000011;
        #1 n_cmp++;
        if (md_if.sftmd !== 1'b1 || md_if.aluc !== 5'b01101 || md_if.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL dec_sra: got sftmd=%b aluc=%b ill=%b want 1/01101/0",
                     md_if.sftmd, md_if.aluc, md_if.illegal);
        end
        md_if.func = 6'b100001;
        #1 n_cmp++;
        if (md_if.sftmd !== 1'b0 || md_if.aluc !== 5'b00000) begin
            n_fail++; $display("FAIL dec_addu: got %b/%b want 0/00000", md_if.sftmd, md_if.aluc);
        end
        set_idle();
    endtask

    task automatic test_multiply();
        int cyc;
        logic [31:0] hi, lo;
        run_md(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, hi, lo);
        n_cmp++;
        if (cyc != 33) begin
            n_fail++; $display("FAIL multu_latency: got %0d want 33", cyc);
        end
        n_cmp++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            n_fail++; $display("FAIL multu_max: got %h/%h want fffffffe/00000001", hi, lo);
        end
        run_md(MULT, 32'hFFFF_FFFD, 32'd5, cyc, hi, lo);
        n_cmp++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            n_fail++; $display("FAIL mult_neg: got %h/%h want ffffffff/fffffff1", hi, lo);
        end
    endtask

    task automatic test_divide();
        int cyc;
        logic [31:0] hi, lo;
        run_md(DIV, 32'hFFFF_FFF9, 32'd2, cyc, hi, lo);
        n_cmp++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL div_neg: got %h/%h want ffffffff/fffffffd", hi, lo);
        end
        run_md(DIVU, 32'd9, 32'd0, cyc, hi, lo);
        n_cmp++;
        if (hi !== 32'd9 || lo !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL divu_zero: got %h/%h want 00000009/ffffffff", hi, lo);
        end
        n_cmp++;
        if (cyc != 33) begin
            n_fail++; $display("FAIL div_latency: got %0d want 33", cyc);
        end
        run_md(DIV, 32'h8000_0000, 32'hFFFF_FFFF, cyc, hi, lo);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_fail++; $display("FAIL div_ovf: got %h/%h want 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_flush();
        logic [31:0] hi, lo;
        @(negedge clk);
        md_if.ex_valid = 1'b1;
        md_if.r_type   = 1'b1;
        md_if.func     = MULT;
        md_if.rs_val   = 32'd1000;
        md_if.rt_val   = 32'd1000;
        repeat (11) @(negedge clk);
        #1 n_cmp++;
        if (md_if.stall !== 1'b1 || md_if.md_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: got stall=%b busy=%b want 1/1", md_if.stall, md_if.md_busy);
        end
        md_if.flush    = 1'b1;
        md_if.ex_valid = 1'b0;
        @(negedge clk);
        md_if.flush = 1'b0;
        #1 n_cmp++;
        if (md_if.stall !== 1'b0 || md_if.md_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_stall: got stall=%b busy=%b want 0/0", md_if.stall, md_if.md_busy);
        end
        set_idle();
        read_hilo(hi, lo);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
            n_fail++; $display("FAIL flush_hilo: got %h/%h want 00000000/80000000", hi, lo);
        end
    endtask

    task automatic test_moves();
        logic [31:0] hi, lo;
        @(negedge clk);
        md_if.ex_valid = 1'b1;
        md_if.r_type   = 1'b1;
        md_if.func     = MTHI;
        md_if.rs_val   = 32'h0000_1234;
        @(negedge clk);
        md_if.func = MTLO;
        md_if.rs_val = 32'h5555_5555;
        md_if.flush  = 1'b1;
        @(negedge clk);
        md_if.flush = 1'b0;
        md_if.func  = MFHI;
        #1 n_cmp++;
        if (md_if.hilo_rd !== 1'b1 || md_if.hilo_rdata !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mthi_mfhi: got rd=%b data=%h want 1/00001234",
                     md_if.hilo_rd, md_if.hilo_rdata);
        end
        set_idle();
        read_hilo(hi, lo);
        n_cmp++;
        if (lo !== 32'h8000_0000) begin
            n_fail++; $display("FAIL mtlo_flushed: got %h want 80000000", lo);
        end
    endtask

    task automatic test_early_out();
        int cyc;
        logic [31:0] hi, lo;
        run_md(MULTU, 32'd2, 32'd1, cyc, hi, lo);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'd2) begin
            n_fail++; $display("FAIL multu_small: got %h/%h want 00000000/00000002", hi, lo);
        end
        n_cmp++;
        if (cyc < 2 || cyc > 33) begin
            n_fail++; $display("FAIL multu_small_latency: got %0d want 2..33", cyc);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] hi, lo;
        run_md(MULTU, 32'd7, 32'd6, cyc, hi, lo);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'd42) begin
            n_fail++; $display("FAIL b2b_mul: got %h/%h want 00000000/0000002a", hi, lo);
        end
        run_md(DIVU, 32'd100, 32'd7, cyc, hi, lo);
        n_cmp++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            n_fail++; $display("FAIL b2b_div: got %h/%h want 00000002/0000000e", hi, lo);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] hi, lo;
        @(negedge clk);
        md_if.ex_valid = 1'b1;
        md_if.r_type   = 1'b1;
        md_if.func     = MULTU;
        md_if.rs_val   = 32'd3;
        md_if.rt_val   = 32'd3;
        repeat (5) @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        #1 n_cmp++;
        if (md_if.md_busy !== 1'b0 || md_if.stall !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got busy=%b stall=%b want 0/0", md_if.md_busy, md_if.stall);
        end
        @(negedge clk);
        rst_n = 1'b1;
        read_hilo(hi, lo);
        n_cmp++;
        if (hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_hilo: got %h/%h want 0/0", hi, lo);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        set_idle();
        test_reset();
        test_decode();
        test_multiply();
        test_divide();
        test_flush();
        test_moves();
        test_early_out();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_md_ctl.md
Name: alu_md_ctl

Overview:
Second-generation EX-stage ALU control, parametrised in datapath width, for the MIPS pipeline.
- Decodes R-type funct into the ALU operation code, shift-mode flag and jr/jalr flags.
- Adds HI/LO registers and an iterative multiply/divide sequencer.
- Stalls the pipeline while mult/multu/div/divu run.

Parameters:
DW, 32, datapath width; HI/LO width; iteration count.
CW, 6, iteration counter width (must hold DW).

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
func  in  6  instruction[5:0] of EX instruction
r_type  in  1  EX instruction is R-type
ex_valid  in  1  EX holds a valid, unflushed instruction
flush  in  1  kill EX instruction / abort mul-div
rs_val  in  DW  forwarded rs operand
rt_val  in  DW  forwarded rt operand
aluc  out  5  ALU operation code
sftmd  out  1  1 = sll/srl/sra (shamt shift)
jr_out  out  1  jr, gated by r_type
jalr_out  out  1  jalr, gated by r_type
illegal  out  1  r_type with undecoded funct
stall  out  1  hold IF/ID/EX
md_busy  out  1  sequencer not IDLE
hilo_rd  out  1  mfhi/mflo in EX; select hilo_rdata
hilo_rdata  out  DW  HI (mfhi) or LO (mflo)

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE, counter 0, HI = LO = 0.
  - stall = md_busy = 0.
  - Combinational outputs follow their inputs.
- Decode is combinational. aluc codes by funct:
  - 100001→00000, 100011→00001, 101010→00010, 100100→00011.
  - 100111→00100, 100101→00101, 100110→00110, 000000→00111.
  - 000010→01000, 101011→01001, 001001→01010, 001000→01011.
  - 000100→01100, 000011→01101, 000111→01110, 000110→01111.
  - mfhi 010000→10000, mthi 010001→10001, mflo 010010→10010, mtlo 010011→10011.
  - mult 011000→10100, multu 011001→10101, div 011010→10110, divu 011011→10111.
  - Any other funct→11111, with illegal = r_type.
- Flag decode:
  - sftmd = 1 for funct 000000, 000010, 000011.
  - jr_out / jalr_out = 0 when r_type = 0.
- Start condition: start = IDLE & ex_valid & r_type & !flush & funct ∈ {mult, multu, div, divu}.
- FSM IDLE → RUN → DONE → IDLE:
  - IDLE: on start, stall = 1 combinationally in the same cycle. Latch |rs|, |rt| (signed ops) or raw values (unsigned ops) and the result signs; clear counter; go to RUN.
  - RUN: stall = 1. Each cycle performs one radix-2 step: shift-add for multiply, restoring subtract for divide. After DW steps (counter == DW−1), write HI/LO with sign correction applied and go to DONE.
  - DONE: stall = 0, so the mul/div instruction retires this cycle without restarting; go to IDLE.
- Latency: DW+1 stall cycles; new HI/LO are visible in the DONE cycle.
- Arithmetic:
  - mult/multu: {HI, LO} = 2·DW-bit product.
  - div/divu: LO = quotient truncated toward zero; HI = remainder carrying the dividend's sign.
  - Divide by zero (any sign): LO = all ones, HI = rs, full latency.
  - Signed overflow (min / −1): LO = min, HI = 0.
- mthi/mtlo: write HI/LO with rs at the clock edge when ex_valid & r_type & !stall & !flush.
- mfhi/mflo: hilo_rd = 1; hilo_rdata presents the current HI/LO (no bypass needed, since a busy sequencer stalls EX).
- flush:
  - In RUN: abort to IDLE; HI/LO unchanged; stall = 0 from the next cycle.
  - In IDLE: suppresses start and mthi/mtlo writes.
- Reset mid-RUN: immediate IDLE, HI/LO cleared.

Optional Feature:
Macro: MD_EARLY_OUT_EN
- Defined: for mult/multu in RUN, if the remaining unshifted multiplier bits are all zero, finish all remaining steps at once and go to DONE at the next edge. Results are identical; latency is ≥2 stall cycles. Divide timing is unchanged.
- Undefined: fixed DW+1 stall cycles for all operations.

Test Plan:
- Reset, then release → stall = 0, md_busy = 0, HI = LO = 0; mfhi gives hilo_rdata = 0.
- multu 0xFFFFFFFF × 0xFFFFFFFF → stall high exactly 33 cycles; then HI = 0xFFFFFFFE, LO = 0x00000001.
- mult −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. With MD_EARLY_OUT_EN and multu 2 × 1 → stall < 33 cycles, same result.
- Division cases:
  - div −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - divu 9 / 0 → LO = 0xFFFFFFFF, HI = 9.
  - div 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- Flush and HI/LO moves:
  - flush on RUN cycle 10 of a mult → stall low the next cycle; HI/LO keep prior values.
  - mthi 0x1234 → mfhi gives hilo_rdata = 0x1234, hilo_rd = 1.
- Decode checks:
  - funct 101010 → aluc 00010.
  - funct 011000 → aluc 10100.
  - funct 001000 with r_type = 0 → jr_out = 0.
  - funct 111111 with r_type = 1 → illegal = 1, aluc 11111.
  - funct 000011 → sftmd = 1.
